seq_detect_ctrl: RTL

//  Sequencer for the serial 1011 sequence detector. Accepts a command word over a

---
 rtl/seq_detect_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// Command sequencer for a serial 1011 detector: clears the detector, streams a word
// into it bit by bit, drains late hits, and returns a saturating hit count.
module seq_detect_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 4,
  parameter int DRAIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] word_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             msb_first,
  output logic             det_rst,
  output logic             det_in,
  input  logic             det_hit,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_ovf
);

  localparam int DW = $clog2(DRAIN + 1);
  localparam int CW = (LEN_W > DW) ? LEN_W : DW;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             sampling;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    if (int'(n) > WIDTH) return LEN_W'(WIDTH);
    return n;
  endfunction

  // Arrange the word so the first bit to transmit sits at bit 0.
  function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] w,
                                                  input logic [LEN_W-1:0] n,
                                                  input logic msb);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    if (msb) return r >> (WIDTH - int'(n));
    return w;
  endfunction

  assign start_ready = rst && (state == S_IDLE);
  assign accept      = start_valid && start_ready;
  assign busy        = (state == S_CLEAR) || (state == S_SHIFT) || (state == S_DRAIN);
  assign done_valid  = (state == S_DONE);
  assign sampling    = (state == S_SHIFT) || (state == S_DRAIN);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_CLEAR;
      S_CLEAR: state_nx = (len_q != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt == CW'(1)) state_nx = S_DRAIN;
      S_DRAIN: if (cnt == CW'(1)) state_nx = S_DONE;
      S_DONE:  if (done_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Detector outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      det_rst   <= 1'b1;
      det_in    <= 1'b0;
      hit_count <= '0;
      hit_ovf   <= 1'b0;
    end else begin
      state   <= state_nx;
      det_rst <= !((state_nx == S_SHIFT) || (state_nx == S_DRAIN));
      det_in  <= (state_nx == S_SHIFT) && sreg[0];
      if (accept) begin
        hit_count <= '0;
        hit_ovf   <= 1'b0;
      end else if (sampling && det_hit) begin
        if (hit_count == CMAX) hit_ovf <= 1'b1;
        else                   hit_count <= hit_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      len_q <= clamp_len(len_in);
      sreg  <= order_bits(word_in, clamp_len(len_in), msb_first);
    end else if (state_nx == S_SHIFT) begin
      sreg <= sreg >> 1;
    end
    if (state == S_CLEAR)                        cnt <= CW'(len_q);
    else if (state == S_SHIFT && cnt == CW'(1))  cnt <= CW'(DRAIN);
    else                                         cnt <= cnt - CW'(1);
  end

endmodule
